// File: rtl/lanzones_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lanzones_pkg
// Description : Shared types and constants for the lanzones instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
package lanzones_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam int WADDR_SHIFT = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  // Byte PC to word address toward the instruction memory.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] pc);
    return pc >> WADDR_SHIFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lanzones_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lanzones_fetch_fifo
// Description : Synchronous FIFO holding fetched {pc,data} words, with flush.
//               Head is read straight from storage (no bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module lanzones_fetch_fifo
  import lanzones_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = XLEN + ILEN
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign pop_en  = pop_i && (count_q != '0);
  assign push_en = push_i && ((count_q < CW'(DEPTH)) || pop_en);

  // Storage, pointers and occupancy; flush empties the FIFO outright.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/lanzones_fetch.sv
`default_nettype none
// ============================================================================
// Module      : lanzones_fetch
// Description : Instruction-fetch initiator. One read outstanding on the
//               R-channel, responses buffered in a PC-tagged FIFO, branch
//               redirects with discard of an in-flight response.
// Revision    : 1.0 - initial release
// ============================================================================
module lanzones_fetch
  import lanzones_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            LEn,
  output logic            RRdy,
  output logic [XLEN-1:0] RAddr,
  input  logic            RVld,
  input  logic [ILEN-1:0] RData,
  input  logic            RedirEn,
  input  logic [XLEN-1:0] RedirPc,
  output logic            IVld,
  input  logic            IRdy,
  output logic [ILEN-1:0] IData,
  output logic [XLEN-1:0] IPc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e     state_q;
  logic             rrdy_q;
  logic [XLEN-1:0]  raddr_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic             kill_q;
  logic             kill_d;

  logic             resp;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             go;
  logic [XLEN+ILEN-1:0] fifo_dout;

  // A response only counts while a request is outstanding; killed or
  // redirect-cycle data is never stored.
  assign resp      = (state_q == ST_REQ) && RVld;
  assign push      = resp && !kill_q && !RedirEn;
  assign pop       = IVld && IRdy;
  // Room is judged on occupancy after this cycle, so the slot for the next
  // response is reserved at issue time.
  assign count_nxt = RedirEn ? '0 : (count + CW'(push) - CW'(pop));
  assign go        = LEn && (count_nxt < CW'(DEPTH));

  // Next request PC and kill flag.
  always_comb begin
    pc_d   = pc_q;
    kill_d = kill_q;
    if (RedirEn) begin
      pc_d   = RedirPc & ~32'h3;
      // An unanswered request cannot be withdrawn; mark its data for discard.
      kill_d = (state_q == ST_REQ) && !RVld;
    end else begin
      if (push) pc_d = pc_q + PC_STEP;
      if (resp) kill_d = 1'b0;
    end
  end

  // Request FSM with registered RRdy/RAddr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      rrdy_q  <= 1'b0;
      raddr_q <= word_addr(RESET_PC);
      pc_q    <= RESET_PC & ~32'h3;
      kill_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_REQ;
            rrdy_q  <= 1'b1;
            raddr_q <= word_addr(pc_d);
          end
        end
        ST_REQ: begin
          if (RVld) begin
            if (go) begin
              raddr_q <= word_addr(pc_d);
            end else begin
              state_q <= ST_IDLE;
              rrdy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rrdy_q  <= 1'b0;
        end
      endcase
    end
  end

  lanzones_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  ({pc_q, RData}),
    .pop_i   (pop),
    .flush_i (RedirEn),
    .data_o  (fifo_dout),
    .valid_o (IVld),
    .count_o (count)
  );

  assign RRdy  = rrdy_q;
  assign RAddr = raddr_q;
  assign IPc   = fifo_dout[XLEN+ILEN-1:ILEN];
  assign IData = fifo_dout[ILEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_lanzones_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_lanzones_fetch
// Description : Self-checking bench for lanzones_fetch with a single-cycle
//               memory responder and a {pc,data} scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lanzones_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        LEn;
  logic        RVld = 1'b0;
  logic [31:0] RData = '0;
  logic        RedirEn;
  logic [31:0] RedirPc;
  logic        IRdy;
  wire         RRdy;
  wire  [31:0] RAddr;
  wire         IVld;
  wire  [31:0] IData;
  wire  [31:0] IPc;

  logic [31:0] mem [64];
  logic        stray;

  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];
  int          rd_idx;
  int          n_cmp;
  int          n_bad;

  always #5 clk = ~clk;

  lanzones_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .LEn     (LEn),
    .RRdy    (RRdy),
    .RAddr   (RAddr),
    .RVld    (RVld),
    .RData   (RData),
    .RedirEn (RedirEn),
    .RedirPc (RedirPc),
    .IVld    (IVld),
    .IRdy    (IRdy),
    .IData   (IData),
    .IPc     (IPc)
  );

  // Single-cycle memory: answers a pending request one cycle later, then rests a cycle.
  always @(posedge clk) begin
    if (RVld) RVld <= 1'b0;
    else if (stray || RRdy === 1'b1) begin
      RVld  <= 1'b1;
      RData <= mem[RAddr[5:0]];
    end
  end

  // Records every word the decoder accepts.
  always @(negedge clk) begin
    if (rstn === 1'b1 && IVld === 1'b1 && IRdy === 1'b1) got_q.push_back({IPc, IData});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; LEn = 1'b0; IRdy = 1'b0; RedirEn = 1'b0; RedirPc = '0; stray = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    rd_idx = got_q.size();
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset;
    rstn = 1'b0; LEn = 1'b0; IRdy = 1'b0; RedirEn = 1'b0; RedirPc = '0; stray = 1'b0;
    #2;
    n_cmp++; if (RRdy !== 1'b0) begin n_bad++; $display("FAIL reset_rrdy: got %b need 0", RRdy); end
    n_cmp++; if (RAddr !== 32'h0) begin n_bad++; $display("FAIL reset_raddr: got %h need 0", RAddr); end
    n_cmp++; if (IVld !== 1'b0) begin n_bad++; $display("FAIL reset_ivld: got %b need 0", IVld); end
    n_cmp++; if (IData !== 32'h0) begin n_bad++; $display("FAIL reset_idata: got %h need 0", IData); end
    n_cmp++; if (IPc !== 32'h0) begin n_bad++; $display("FAIL reset_ipc: got %h need 0", IPc); end
    tick(); tick();
    rstn = 1'b1;
    tick(); tick();
    n_cmp++; if (RRdy !== 1'b0) begin n_bad++; $display("FAIL idle_no_len: got RRdy %b need 0", RRdy); end
  endtask

  task automatic test_stream;
    int seen, gaps;
    do_reset();
    exp_q.push_back({32'd0, 32'd13});  exp_q.push_back({32'd4, 32'd93});
    exp_q.push_back({32'd8, 32'd113}); exp_q.push_back({32'd12, 32'd193});
    LEn = 1'b1; IRdy = 1'b1; seen = 0; gaps = 0;
    for (int k = 0; k < 60 && (got_q.size() - rd_idx) < exp_q.size(); k++) begin
      tick();
      if (RRdy === 1'b1) seen = 1;
      else if (seen != 0) gaps++;
    end
    IRdy = 1'b0; LEn = 1'b0;
    n_cmp++; if (gaps != 0 || seen == 0) begin n_bad++; $display("FAIL stream_rrdy: got %0d low cycles (seen=%0d) need 0", gaps, seen); end
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= got_q.size()) begin n_bad++; $display("FAIL stream_word: got nothing need %h", exp_q[0]); end
      else begin
        if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL stream_word: got %h need %h", got_q[rd_idx], exp_q[0]); end
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_full;
    int comp;
    do_reset();
    LEn = 1'b1; IRdy = 1'b0; comp = 0;
    for (int k = 0; k < 30; k++) begin
      if (RRdy === 1'b1 && RVld === 1'b1) comp++;
      tick();
    end
    n_cmp++; if (comp != DEPTH) begin n_bad++; $display("FAIL full_count: got %0d responses need %0d", comp, DEPTH); end
    n_cmp++; if (RRdy !== 1'b0) begin n_bad++; $display("FAIL full_rrdy: got %b need 0", RRdy); end
    n_cmp++; if (IVld !== 1'b1 || IPc !== 32'h0) begin n_bad++; $display("FAIL full_head: got IVld %b IPc %h need 1 0", IVld, IPc); end
    exp_q.push_back({32'd0, 32'd13});  exp_q.push_back({32'd4, 32'd93});
    exp_q.push_back({32'd8, 32'd113}); exp_q.push_back({32'd12, 32'd193});
    exp_q.push_back({32'd16, mem[4]}); exp_q.push_back({32'd20, mem[5]});
    IRdy = 1'b1;
    for (int k = 0; k < 80 && (got_q.size() - rd_idx) < exp_q.size(); k++) tick();
    IRdy = 1'b0; LEn = 1'b0;
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= got_q.size()) begin n_bad++; $display("FAIL full_word: got nothing need %h", exp_q[0]); end
      else begin
        if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL full_word: got %h need %h", got_q[rd_idx], exp_q[0]); end
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_redir_kill;
    logic [31:0] held;
    do_reset();
    IRdy = 1'b1; LEn = 1'b1;
    tick();
    for (int k = 0; k < 20 && !(RRdy === 1'b1 && RVld === 1'b0); k++) tick();
    n_cmp++; if (!(RRdy === 1'b1 && RVld === 1'b0)) begin n_bad++; $display("FAIL kill_wait: got RRdy %b RVld %b need 1 0", RRdy, RVld); end
    held = RAddr;
    RedirEn = 1'b1; RedirPc = 32'h40;
    tick();
    RedirEn = 1'b0;
    n_cmp++; if (RAddr !== held || RRdy !== 1'b1) begin n_bad++; $display("FAIL kill_hold: got RAddr %h RRdy %b need %h 1", RAddr, RRdy, held); end
    tick();
    n_cmp++; if (RAddr !== 32'h10 || IVld !== 1'b0) begin n_bad++; $display("FAIL kill_next: got RAddr %h IVld %b need 10 0", RAddr, IVld); end
    exp_q.push_back({32'h40, mem[16]}); exp_q.push_back({32'h44, mem[17]});
    for (int k = 0; k < 40 && (got_q.size() - rd_idx) < exp_q.size(); k++) tick();
    IRdy = 1'b0; LEn = 1'b0;
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= got_q.size()) begin n_bad++; $display("FAIL kill_word: got nothing need %h", exp_q[0]); end
      else begin
        if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL kill_word: got %h need %h", got_q[rd_idx], exp_q[0]); end
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_redir_rvld;
    do_reset();
    IRdy = 1'b0; LEn = 1'b1;
    for (int k = 0; k < 30 && !(RRdy === 1'b1 && RVld === 1'b1 && RAddr === 32'd2); k++) tick();
    n_cmp++; if (!(RRdy === 1'b1 && RVld === 1'b1 && RAddr === 32'd2)) begin n_bad++; $display("FAIL rvld_wait: got RAddr %h RVld %b need 2 1", RAddr, RVld); end
    RedirEn = 1'b1; RedirPc = 32'h43;
    tick();
    RedirEn = 1'b0;
    n_cmp++; if (IVld !== 1'b0) begin n_bad++; $display("FAIL rvld_flush: got IVld %b need 0", IVld); end
    n_cmp++; if (RAddr !== 32'h10 || RRdy !== 1'b1) begin n_bad++; $display("FAIL rvld_next: got RAddr %h RRdy %b need 10 1", RAddr, RRdy); end
    exp_q.push_back({32'h40, mem[16]}); exp_q.push_back({32'h44, mem[17]});
    IRdy = 1'b1;
    for (int k = 0; k < 40 && (got_q.size() - rd_idx) < exp_q.size(); k++) tick();
    IRdy = 1'b0; LEn = 1'b0;
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= got_q.size()) begin n_bad++; $display("FAIL rvld_word: got nothing need %h", exp_q[0]); end
      else begin
        if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL rvld_word: got %h need %h", got_q[rd_idx], exp_q[0]); end
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_len_drop;
    int hi;
    do_reset();
    IRdy = 1'b1; LEn = 1'b1;
    for (int k = 0; k < 30 && !(RRdy === 1'b1 && RVld === 1'b0 && RAddr === 32'd1); k++) tick();
    n_cmp++; if (!(RRdy === 1'b1 && RVld === 1'b0 && RAddr === 32'd1)) begin n_bad++; $display("FAIL len_wait: got RAddr %h RVld %b need 1 0", RAddr, RVld); end
    LEn = 1'b0;
    exp_q.push_back({32'd0, 32'd13}); exp_q.push_back({32'd4, 32'd93});
    tick(); tick();
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (RRdy !== 1'b0) hi++;
      tick();
    end
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL len_quiet: got %0d RRdy-high cycles need 0", hi); end
    LEn = 1'b1;
    tick();
    n_cmp++; if (RAddr !== 32'd2 || RRdy !== 1'b1) begin n_bad++; $display("FAIL len_resume: got RAddr %h RRdy %b need 2 1", RAddr, RRdy); end
    exp_q.push_back({32'd8, 32'd113}); exp_q.push_back({32'd12, 32'd193});
    for (int k = 0; k < 40 && (got_q.size() - rd_idx) < exp_q.size(); k++) tick();
    IRdy = 1'b0; LEn = 1'b0;
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= got_q.size()) begin n_bad++; $display("FAIL len_word: got nothing need %h", exp_q[0]); end
      else begin
        if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL len_word: got %h need %h", got_q[rd_idx], exp_q[0]); end
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_wrap;
    do_reset();
    IRdy = 1'b1; LEn = 1'b1; RedirEn = 1'b1; RedirPc = 32'hFFFF_FFFE;
    tick();
    RedirEn = 1'b0;
    n_cmp++; if (RAddr !== 32'h3FFF_FFFF || RRdy !== 1'b1) begin n_bad++; $display("FAIL wrap_addr: got RAddr %h RRdy %b need 3fffffff 1", RAddr, RRdy); end
    exp_q.push_back({32'hFFFF_FFFC, mem[63]}); exp_q.push_back({32'h0, 32'd13});
    for (int k = 0; k < 40 && (got_q.size() - rd_idx) < exp_q.size(); k++) tick();
    IRdy = 1'b0; LEn = 1'b0;
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= got_q.size()) begin n_bad++; $display("FAIL wrap_word: got nothing need %h", exp_q[0]); end
      else begin
        if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL wrap_word: got %h need %h", got_q[rd_idx], exp_q[0]); end
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_stray_idle;
    do_reset();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick(); tick();
    n_cmp++; if (IVld !== 1'b0 || RRdy !== 1'b0) begin n_bad++; $display("FAIL stray_rvld: got IVld %b RRdy %b need 0 0", IVld, RRdy); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    IRdy = 1'b0; LEn = 1'b1;
    for (int k = 0; k < 30 && !(RRdy === 1'b1 && RAddr === 32'd1); k++) tick();
    n_cmp++; if (!(RRdy === 1'b1 && RAddr === 32'd1 && IVld === 1'b1)) begin n_bad++; $display("FAIL rst_wait: got RAddr %h IVld %b need 1 1", RAddr, IVld); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (RRdy !== 1'b0 || IVld !== 1'b0) begin n_bad++; $display("FAIL rst_async: got RRdy %b IVld %b need 0 0", RRdy, IVld); end
    n_cmp++; if (RAddr !== 32'h0) begin n_bad++; $display("FAIL rst_raddr: got %h need 0", RAddr); end
    LEn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    rd_idx = got_q.size();
    exp_q.delete();
    tick(); tick();
    n_cmp++; if (IVld !== 1'b0 || RRdy !== 1'b0) begin n_bad++; $display("FAIL rst_after: got IVld %b RRdy %b need 0 0", IVld, RRdy); end
    LEn = 1'b1; IRdy = 1'b1;
    tick();
    n_cmp++; if (RAddr !== 32'h0 || RRdy !== 1'b1) begin n_bad++; $display("FAIL rst_restart: got RAddr %h RRdy %b need 0 1", RAddr, RRdy); end
    exp_q.push_back({32'd0, 32'd13}); exp_q.push_back({32'd4, 32'd93});
    for (int k = 0; k < 40 && (got_q.size() - rd_idx) < exp_q.size(); k++) tick();
    IRdy = 1'b0; LEn = 1'b0;
    while (exp_q.size() > 0) begin
      n_cmp++;
      if (rd_idx >= got_q.size()) begin n_bad++; $display("FAIL rst_word: got nothing need %h", exp_q[0]); end
      else begin
        if (got_q[rd_idx] !== exp_q[0]) begin n_bad++; $display("FAIL rst_word: got %h need %h", got_q[rd_idx], exp_q[0]); end
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; rd_idx = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[0] = 32'd13; mem[1] = 32'd93; mem[2] = 32'd113; mem[3] = 32'd193;
    test_reset();
    test_stream();
    test_full();
    test_redir_kill();
    test_redir_rvld();
    test_len_drop();
    test_wrap();
    test_stray_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
